// File: rtl/scoreboard_pkg.sv
// Shared scoreboard types and constants: FSM state encoding, BCD digit width
// and the default debounce length.
package scoreboard_pkg;

  typedef enum logic {
    PLAY = 1'b0,
    WON  = 1'b1
  } state_t;

  localparam int DIGIT_W           = 4;
  localparam int DB_CYCLES_DEFAULT = 240000;

endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low push-button; emits a 1-cycle pulse on press only.
// Latency: about DB_CYCLES+2 cycles from raw edge to pulse; no backpressure, pulse is fire-and-forget.
module key_debounce
  import scoreboard_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DB_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    // Any cycle where the synchronised level matches the stable one restarts the count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        stable_d = sync2_q;
        pulse_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/score_counter.sv
// Debounced add/sub/clear buttons driving a two-digit BCD score with a win latch at WIN_SCORE.
// Latency: score/win update one cycle after the press pulse (~DB_CYCLES+3 from raw edge); no backpressure.
module score_counter
  import scoreboard_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int WIN_SCORE = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_add_n,
  input  logic               key_sub_n,
  input  logic               key_clr_n,
  output logic [DIGIT_W-1:0] seg_data_1,
  output logic [DIGIT_W-1:0] seg_data_2,
  output logic               win
);

  localparam logic [DIGIT_W-1:0] WIN_TENS  = DIGIT_W'(WIN_SCORE / 10);
  localparam logic [DIGIT_W-1:0] WIN_UNITS = DIGIT_W'(WIN_SCORE % 10);
  localparam logic [DIGIT_W-1:0] NINE      = DIGIT_W'(9);
  localparam logic [DIGIT_W-1:0] ONE       = DIGIT_W'(1);

  // Reset asserts asynchronously but is released in step with clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  logic add_p, sub_p, clr_p;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_add (
    .clk(clk), .rst_n(rst_int_n), .key_n(key_add_n), .press_pulse(add_p));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sub (
    .clk(clk), .rst_n(rst_int_n), .key_n(key_sub_n), .press_pulse(sub_p));
  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_int_n), .key_n(key_clr_n), .press_pulse(clr_p));

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] tens_q, tens_d, units_q, units_d;
  logic               win_q, win_d;
  logic [DIGIT_W-1:0] inc_tens, inc_units, dec_tens, dec_units;
  logic               at_zero;

  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    units_d   = units_q;
    inc_tens  = tens_q;
    inc_units = units_q + ONE;
    dec_tens  = tens_q;
    dec_units = units_q - ONE;
    at_zero   = (tens_q == '0) && (units_q == '0);

    if (units_q == NINE) begin
      inc_units = '0;
      inc_tens  = tens_q + ONE;
    end
    if (units_q == '0) begin
      dec_units = NINE;
      dec_tens  = tens_q - ONE;
    end

    if (clr_p) begin
      tens_d  = '0;
      units_d = '0;
      state_d = PLAY;
    end else if (state_q == PLAY) begin
      if (add_p && !sub_p) begin
        tens_d  = inc_tens;
        units_d = inc_units;
        if (inc_tens == WIN_TENS && inc_units == WIN_UNITS) state_d = WON;
      end else if (sub_p && !add_p && !at_zero) begin
        tens_d  = dec_tens;
        units_d = dec_units;
      end
    end

    win_d = (state_d == WON);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= PLAY;
      tens_q  <= '0;
      units_q <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      win_q   <= win_d;
    end
  end

  assign seg_data_1 = tens_q;
  assign seg_data_2 = units_q;
  assign win        = win_q;

endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter with a short debounce window (DB_CYCLES=4, WIN_SCORE=21).
module tb_score_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_add_n = 1'b1;
  logic       key_sub_n = 1'b1;
  logic       key_clr_n = 1'b1;
  logic [3:0] seg_data_1, seg_data_2;
  logic       win;

  int passed = 0;
  int total  = 0;
  logic bcd_bad = 1'b0;

  score_counter #(.DB_CYCLES(4), .WIN_SCORE(21)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_add_n(key_add_n), .key_sub_n(key_sub_n), .key_clr_n(key_clr_n),
    .seg_data_1(seg_data_1), .seg_data_2(seg_data_2), .win(win)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (seg_data_1 > 4'd9 || seg_data_2 > 4'd9)) bcd_bad = 1'b1;
  end

  function automatic logic [8:0] expv(input int score, input logic w);
    logic [3:0] t, u;
    t = 4'(score / 10);
    u = 4'(score % 10);
    return {t, u, w};
  endfunction

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
    total = total + 1;
    assert (obs === exp_v) passed = passed + 1;
    else $error("FAIL %s observed tens/units/win=%h/%h/%b expected=%h/%h/%b",
                tag, obs[8:5], obs[4:1], obs[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
  endtask

  function automatic logic [8:0] outs();
    return {seg_data_1, seg_data_2, win};
  endfunction

  // Drives the selected keys low at a falling edge: checks the old value just before
  // the expected update edge, the new value right after it, then releases and settles.
  task automatic press(input logic a, input logic s, input logic c, input string tag,
                       input int sc_before, input logic w_before,
                       input int sc_after, input logic w_after);
    key_add_n = ~a;
    key_sub_n = ~s;
    key_clr_n = ~c;
    repeat (6) @(negedge clk);
    check({tag, "_before"}, outs(), expv(sc_before, w_before));
    @(negedge clk);
    check({tag, "_after"}, outs(), expv(sc_after, w_after));
    repeat (3) @(negedge clk);
    key_add_n = 1'b1;
    key_sub_n = 1'b1;
    key_clr_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_asserted", outs(), expv(0, 1'b0));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_released", outs(), expv(0, 1'b0));

    press(1'b0, 1'b1, 1'b0, "sub_at_00", 0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 1'b0, "add_count", i, 1'b0, i + 1, 1'b0);

    press(1'b0, 1'b1, 1'b0, "sub_10_to_09", 10, 1'b0, 9, 1'b0);

    // Two-cycle bounces never survive four stable cycles.
    for (int i = 0; i < 5; i++) begin
      key_add_n = 1'b0;
      repeat (2) @(negedge clk);
      key_add_n = 1'b1;
      repeat (2) @(negedge clk);
    end
    check("bounce_rejected", outs(), expv(9, 1'b0));
    press(1'b1, 1'b0, 1'b0, "bounce_then_hold", 9, 1'b0, 10, 1'b0);
    check("release_no_pulse", outs(), expv(10, 1'b0));

    press(1'b0, 1'b0, 1'b1, "clr_play", 10, 1'b0, 0, 1'b0);

    for (int i = 0; i < 21; i++)
      press(1'b1, 1'b0, 1'b0, "add_to_win", i, 1'b0, i + 1, (i == 20));

    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b0, "add_in_won", 21, 1'b1, 21, 1'b1);
    press(1'b0, 1'b1, 1'b0, "sub_in_won", 21, 1'b1, 21, 1'b1);
    press(1'b0, 1'b0, 1'b1, "clr_in_won", 21, 1'b1, 0, 1'b0);
    press(1'b1, 1'b0, 1'b0, "add_after_clr", 0, 1'b0, 1, 1'b0);

    for (int i = 1; i < 5; i++) press(1'b1, 1'b0, 1'b0, "add_to_05", i, 1'b0, i + 1, 1'b0);
    press(1'b1, 1'b1, 1'b0, "add_sub_same", 5, 1'b0, 5, 1'b0);
    press(1'b1, 1'b0, 1'b1, "clr_beats_add", 5, 1'b0, 0, 1'b0);

    press(1'b1, 1'b0, 1'b0, "add_before_rst", 0, 1'b0, 1, 1'b0);
    key_add_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", outs(), expv(0, 1'b0));
    key_add_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_mid_press_no_pulse", outs(), expv(0, 1'b0));
    press(1'b1, 1'b0, 1'b0, "add_after_rst", 0, 1'b0, 1, 1'b0);

    check("bcd_always_valid", {8'h00, bcd_bad}, 9'h000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/score_counter.md
Name: score_counter

Overview:
- Upstream feeder of the two-digit segment decoder in the ball-competition scoreboard.
- Turns three raw push-buttons (add, subtract, clear) into a debounced decimal score of 0..99.
- Presents the score as two BCD nibbles: tens on seg_data_1, units on seg_data_2.
- A small FSM stops scoring once the winning score is reached and raises a win flag until cleared.

Parameters:
- DB_CYCLES, 240000, number of consecutive stable clk cycles a synchronised key must hold before it is accepted (20 ms at 12 MHz); legal range >= 2.
- WIN_SCORE, 21, decimal score that ends the match; legal range 1..99.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_add_n  input  1  raw add button, active-low, asynchronous to clk, bouncy.
- key_sub_n  input  1  raw subtract button, active-low, asynchronous, bouncy.
- key_clr_n  input  1  raw clear button, active-low, asynchronous, bouncy.
- seg_data_1  output  4  tens digit, BCD 0..9.
- seg_data_2  output  4  units digit, BCD 0..9.
- win  output  1  high while the FSM is in WON.

Behaviour:
- Reset:
  - Asynchronous assert, synchronous release.
  - seg_data_1=0, seg_data_2=0, win=0, FSM=PLAY.
  - All debouncers: stable level=1 (released), counters=0, synchronisers=1.
- Key path, per key:
  - 2-FF synchroniser.
  - Counter increments while the synchronised level differs from the stable level.
  - Counter clears to 0 on any cycle where they match; a bounce therefore restarts the count.
  - When the counter reaches DB_CYCLES-1 with a mismatch still present, the stable level takes the new value and the counter clears.
  - A one-cycle press pulse is emitted on the stable 1->0 transition only. Release produces no pulse.
  - Holding a key produces no auto-repeat.
- Latency: score and win change on the clk edge after the pulse cycle. Total from the raw edge is about DB_CYCLES+3 cycles.
- Score register:
  - Two BCD nibbles; never holds a non-BCD value.
  - Increment: units 9 -> 0 with tens+1.
  - Decrement: units 0 -> 9 with tens-1.
  - Comparison against WIN_SCORE uses tens*10+units, or equivalent BCD constants derived from the parameter.
- FSM states PLAY, WON. Pulse priority is clr > (add, sub).
  - In PLAY, clr pulse: score -> 00, stay in PLAY.
  - In PLAY, add only:
    - If score+1 == WIN_SCORE: score -> WIN_SCORE, go to WON.
    - Otherwise: score+1.
  - In PLAY, sub only:
    - At 00: ignored, score stays 00.
    - Otherwise: score-1.
  - In PLAY, add and sub in the same cycle: no change.
  - In WON: add and sub are ignored; score is frozen at WIN_SCORE.
  - In WON, clr pulse: score -> 00, win -> 0, go to PLAY.
- win is a registered decode of state WON; it goes high in the same cycle the score shows WIN_SCORE.
- 99 ceiling: WIN_SCORE <= 99 means score never exceeds 99, so no wrap is possible.
- Reset mid-debounce: any partially counted press is discarded and no pulse is emitted afterwards. Release of rst_n with a key held low is accepted as a press after DB_CYCLES.

Decomposition:
- Shared package scoreboard_pkg holds:
  - State encoding PLAY=1'b0, WON=1'b1.
  - BCD digit width constant of 4.
  - Default DB_CYCLES.
- One sub-module, key_debounce:
  - Parameter DB_CYCLES.
  - Ports clk, rst_n, key_n, press_pulse.
  - Instantiated three times.
- BCD increment, decrement and compare stay in the top level.

Test Plan:
- Sim with DB_CYCLES=4, WIN_SCORE=21. After reset -> seg_data_1=0, seg_data_2=0, win=0.
- Add pressed 10 times, clean 10-cycle lows -> score 1,2,...,9 then 1/0; no non-BCD values ever.
- key_add_n toggles every 2 cycles for 20 cycles, then holds low for 10 -> exactly one increment, about 7 cycles after the final stable edge.
- From 00, pulse sub -> score stays 00. Then from 10, pulse sub -> score 0/9.
- Add 21 times -> score 2/1 with win=1 on the same edge. Then 3 further adds -> no change. Then clr -> 0/0, win=0, next add -> 0/1.
- add and sub pressed simultaneously at score 05 -> stays 05.
- clr together with add at score 05 -> 00.
- rst_n low for 1 cycle in the middle of a press count -> no pulse and outputs 0.
